pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
Sequences the pipelined core around multi-cycle data-memory accesses and pipeline hazards. Drives the control unit's Stuck input and the per-stage stall/flush lines. Runs a req/ack handshake with data memory for the instruction in the MEM stage. Detects load-use hazards between EX and DECODE, and flushes on taken branches.

Parameters:
TIMEOUT_CYCLES, 16, max WAIT cycles without mem_ack before forced release
REG_W, 4, register index width (matches Rd width of control unit)

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-high reset
MemAccessM  input  1  instruction in MEM stage is a load or store
MemWriteM  input  1  MEM-stage instruction is a store
mem_ack  input  1  data memory completes current access (one-cycle pulse)
MemtoRegE  input  1  EX-stage instruction is a load
RegWriteE  input  1  EX-stage instruction writes a register
RdE  input  REG_W  EX-stage destination register
Rn_D  input  REG_W  DECODE source register 1
Rm_D  input  REG_W  DECODE source register 2
BranchTakenE  input  1  branch resolved taken in EX
Stuck  output  1  freeze whole pipeline (to control unit and all stage registers)
StallF  output  1  hold PC / FETCH register
StallD  output  1  hold DECODE register
FlushD  output  1  bubble DECODE register
FlushE  output  1  bubble EX register
mem_req  output  1  access request to data memory
mem_we  output  1  write enable qualifying mem_req
busy  output  1  FSM not in IDLE
timeout_err  output  1  sticky timeout flag
stall_cycles  output  32  cycles with Stuck=1 (see Optional Feature)
mem_accesses  output  32  completed memory accesses (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE, timeout counter 0. mem_req, mem_we, timeout_err and counters go 0. All combinational outputs evaluate from IDLE.
- FSM states:
  - IDLE → WAIT when MemAccessM=1.
  - WAIT → RELEASE on mem_ack=1, or when the counter reaches TIMEOUT_CYCLES-1 without ack.
  - RELEASE → IDLE unconditionally.
- mem_req and mem_we are registered, high exactly while in WAIT. mem_we is captured from MemWriteM on the IDLE→WAIT transition.
- Stuck = (IDLE & MemAccessM) | WAIT. Stuck is 0 in RELEASE so the served instruction leaves MEM.
- Latency: access enters MEM at cycle t; mem_req at t+1; ack at t+k; RELEASE at t+k+1. Minimum Stuck duration is 2 cycles (ack at t+1).
- A back-to-back access entering MEM in the cycle after RELEASE starts a new IDLE→WAIT sequence with no gap.
- mem_ack is ignored in IDLE and RELEASE.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). Clears on WAIT entry and increments each WAIT cycle without ack. On timeout, timeout_err sets and stays set until rst.
- Load-use hazard: LU = MemtoRegE & RegWriteE & (RdE==Rn_D | RdE==Rm_D). LU drives StallF=StallD=1 and FlushE=1.
- Branch: BranchTakenE drives FlushD=1 and FlushE=1. A branch overrides LU: StallF=StallD=0, flushes asserted.
- Stuck priority: while Stuck=1, StallF=StallD=1 and FlushD=FlushE=0. Hazards re-evaluate once Stuck drops.
- busy = (state != IDLE).
- rst asserted mid-WAIT drops mem_req immediately. The memory must discard the in-flight access.

Optional Feature:
- Macro: PIPELINE_STALL_STATS_EN.
- Defined: stall_cycles increments each cycle Stuck=1. mem_accesses increments on each WAIT→RELEASE transition. Both saturate at 2^32-1 and reset to 0.
- Undefined: both ports tied to 0 and no counter flops are inferred.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - stall_state_t enum {IDLE, WAIT, RELEASE}
  - REG_W_DEFAULT constant
  - STAT_W=32 constant
- Natural sub-module: hazard_detect, combinational LU and branch flush logic. Its outputs are masked by Stuck in the top.

Test Plan:
- Load at t with mem_ack at t+1 → Stuck high t..t+1, mem_req high t+1 only, RELEASE at t+2, Stuck low t+2.
- Store with ack at t+5 → mem_we=1 during WAIT, Stuck high t..t+5, mem_accesses=1 (macro on).
- No ack for 16 WAIT cycles → forced RELEASE, timeout_err=1 and stays 1 until rst.
- MemtoRegE=1, RegWriteE=1, RdE=3, Rn_D=3, no MEM access → StallF=StallD=FlushE=1, FlushD=0. Same case with Rn_D=Rm_D=4 → all 0.
- BranchTakenE=1 during a 3-cycle Stuck → no flushes while Stuck; FlushD=FlushE=1 in the first non-Stuck cycle the branch is still present.
- rst pulsed mid-WAIT → mem_req, busy and Stuck low the same cycle; stall_cycles=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipeline_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RELEASE} stall_state_t;

   localparam int REG_W_DEFAULT = 4;
   localparam int STAT_W        = 32;

   // Raw hazard response before the memory freeze masks it
   typedef struct packed {
      logic stall;
      logic flush_d;
      logic flush_e;
   } hazard_t;
endpackage

// File: rtl/pipeline_stall_controller_hazard.sv
// Combinational load-use and taken-branch hazard detection.
module hazard_detect
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_W = REG_W_DEFAULT
) (
   input  logic             MemtoRegE,
   input  logic             RegWriteE,
   input  logic [REG_W-1:0] RdE,
   input  logic [REG_W-1:0] Rn_D,
   input  logic [REG_W-1:0] Rm_D,
   input  logic             BranchTakenE,
   output hazard_t          hz
);
   logic lu;

   assign lu = MemtoRegE & RegWriteE & ((RdE == Rn_D) | (RdE == Rm_D));

   // A taken branch squashes the dependent instruction, so it wins over LU
   assign hz.stall   = lu & ~BranchTakenE;
   assign hz.flush_d = BranchTakenE;
   assign hz.flush_e = BranchTakenE | lu;
endmodule

// File: rtl/pipeline_stall_controller.sv
// Freezes the pipeline around data-memory accesses and resolves EX/DECODE hazards.
// Define PIPELINE_STALL_STATS_EN to build the stall/access statistic counters.
module pipeline_stall_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int REG_W          = REG_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemAccessM,
   input  logic              MemWriteM,
   input  logic              mem_ack,
   input  logic              MemtoRegE,
   input  logic              RegWriteE,
   input  logic [REG_W-1:0]  RdE,
   input  logic [REG_W-1:0]  Rn_D,
   input  logic [REG_W-1:0]  Rm_D,
   input  logic              BranchTakenE,
   output logic              Stuck,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic              mem_req,
   output logic              mem_we,
   output logic              busy,
   output logic              timeout_err,
   output logic [STAT_W-1:0] stall_cycles,
   output logic [STAT_W-1:0] mem_accesses
);
   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   stall_state_t   state;
   logic [CNT_W-1:0] cnt;
   hazard_t        hz;
   logic           wait_exit;
   logic           timeout_hit;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .MemtoRegE    (MemtoRegE),
      .RegWriteE    (RegWriteE),
      .RdE          (RdE),
      .Rn_D         (Rn_D),
      .Rm_D         (Rm_D),
      .BranchTakenE (BranchTakenE),
      .hz           (hz)
   );

   assign wait_exit   = (state == WAIT) & (mem_ack | (cnt == CNT_LAST));
   assign timeout_hit = (state == WAIT) & ~mem_ack & (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (MemAccessM) begin
                  state   <= WAIT;
                  cnt     <= '0;
                  mem_req <= 1'b1;
                  mem_we  <= MemWriteM;
               end
            end
            WAIT: begin
               if (wait_exit) begin
                  state   <= RELEASE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (timeout_hit) timeout_err <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // RELEASE deliberately drops Stuck so the served instruction can leave MEM
   assign Stuck  = ((state == IDLE) & MemAccessM) | (state == WAIT);
   assign busy   = (state != IDLE);
   assign StallF = Stuck | hz.stall;
   assign StallD = Stuck | hz.stall;
   assign FlushD = ~Stuck & hz.flush_d;
   assign FlushE = ~Stuck & hz.flush_e;

`ifdef PIPELINE_STALL_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         mem_accesses <= '0;
      end else begin
         if (Stuck && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
         if (wait_exit && (mem_accesses != '1)) mem_accesses <= mem_accesses + 1'b1;
      end
   end
`else
   assign stall_cycles = '0;
   assign mem_accesses = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench: memory handshake, timeout, hazards, stuck priority and mid-access reset.
module tb_pipeline_stall_controller;
   logic        clk, rst;
   logic        MemAccessM, MemWriteM, mem_ack;
   logic        MemtoRegE, RegWriteE, BranchTakenE;
   logic [3:0]  RdE, Rn_D, Rm_D;
   logic        Stuck, StallF, StallD, FlushD, FlushE;
   logic        mem_req, mem_we, busy, timeout_err;
   logic [31:0] stall_cycles, mem_accesses;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef PIPELINE_STALL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   pipeline_stall_controller #(.TIMEOUT_CYCLES(16), .REG_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .MemAccessM   (MemAccessM),
      .MemWriteM    (MemWriteM),
      .mem_ack      (mem_ack),
      .MemtoRegE    (MemtoRegE),
      .RegWriteE    (RegWriteE),
      .RdE          (RdE),
      .Rn_D         (Rn_D),
      .Rm_D         (Rm_D),
      .BranchTakenE (BranchTakenE),
      .Stuck        (Stuck),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .FlushE       (FlushE),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .stall_cycles (stall_cycles),
      .mem_accesses (mem_accesses)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench 2 time units after a rising edge
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] st(input int n);
      return STATS ? 32'(n) : 32'd0;
   endfunction

   initial begin
      rst = 1'b1;
      MemAccessM = 0; MemWriteM = 0; mem_ack = 0;
      MemtoRegE = 0; RegWriteE = 0; BranchTakenE = 0;
      RdE = 0; Rn_D = 4'd1; Rm_D = 4'd2;
      #1;
      chk("rst_stuck", Stuck, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_stall_cycles", stall_cycles, 0);
      chk("rst_mem_accesses", mem_accesses, 0);
      #16 rst = 1'b0;
      cyc();

      // Load, ack one cycle after request
      MemAccessM = 1; #1;
      chk("ld_t_stuck", Stuck, 1);
      chk("ld_t_req", mem_req, 0);
      chk("ld_t_stallf", StallF, 1);
      cyc();
      mem_ack = 1; #1;
      chk("ld_t1_stuck", Stuck, 1);
      chk("ld_t1_req", mem_req, 1);
      chk("ld_t1_we", mem_we, 0);
      chk("ld_t1_busy", busy, 1);
      cyc();
      mem_ack = 0; #1;
      chk("ld_t2_stuck", Stuck, 0);
      chk("ld_t2_req", mem_req, 0);
      chk("ld_t2_busy", busy, 1);
      chk("ld_t2_stallf", StallF, 0);
      chk("ld_t2_stall_cycles", stall_cycles, st(2));
      cyc();

      // Back-to-back store, ack at t+5
      MemWriteM = 1; #1;
      chk("st_t_busy", busy, 0);
      chk("st_t_stuck", Stuck, 1);
      chk("st_t_mem_accesses", mem_accesses, st(1));
      cyc();
      chk("st_t1_we", mem_we, 1);
      chk("st_t1_req", mem_req, 1);
      for (int i = 1; i <= 4; i++) begin
         chk("st_wait_stuck", Stuck, 1);
         cyc();
      end
      mem_ack = 1; #1;
      chk("st_t5_stuck", Stuck, 1);
      chk("st_t5_we", mem_we, 1);
      cyc();
      mem_ack = 0; #1;
      chk("st_t6_stuck", Stuck, 0);
      chk("st_t6_we", mem_we, 0);
      cyc();
      MemAccessM = 0; MemWriteM = 0; #1;
      chk("st_idle_busy", busy, 0);
      chk("st_mem_accesses", mem_accesses, st(2));
      chk("st_stall_cycles", stall_cycles, st(8));
      chk("st_timeout", timeout_err, 0);
      cyc();

      // Timeout: 16 WAIT cycles without ack
      MemAccessM = 1; #1;
      cyc();
      for (int i = 1; i <= 16; i++) begin
         chk("to_wait_stuck", Stuck, 1);
         chk("to_wait_err", timeout_err, 0);
         cyc();
      end
      mem_ack = 1; #1;
      chk("to_rel_stuck", Stuck, 0);
      chk("to_rel_req", mem_req, 0);
      chk("to_rel_busy", busy, 1);
      chk("to_rel_err", timeout_err, 1);
      cyc();
      MemAccessM = 0; #1;
      chk("to_late_ack_busy", busy, 0);
      chk("to_mem_accesses", mem_accesses, st(3));
      chk("to_stall_cycles", stall_cycles, st(25));
      cyc();
      mem_ack = 0; #1;
      chk("idle_ack_ignored", busy, 0);
      chk("to_err_sticky", timeout_err, 1);

      // Load-use hazard, no memory access
      MemtoRegE = 1; RegWriteE = 1; RdE = 4'd3; Rn_D = 4'd3; Rm_D = 4'd0; #1;
      chk("lu_rn_stallf", StallF, 1);
      chk("lu_rn_stalld", StallD, 1);
      chk("lu_rn_flushe", FlushE, 1);
      chk("lu_rn_flushd", FlushD, 0);
      Rn_D = 4'd4; Rm_D = 4'd4; #1;
      chk("lu_none_stallf", StallF, 0);
      chk("lu_none_flushe", FlushE, 0);
      Rn_D = 4'd5; Rm_D = 4'd3; #1;
      chk("lu_rm_stalld", StallD, 1);
      RegWriteE = 0; #1;
      chk("lu_nowrite_flushe", FlushE, 0);
      RegWriteE = 1; BranchTakenE = 1; #1;
      chk("br_over_lu_stallf", StallF, 0);
      chk("br_over_lu_flushd", FlushD, 1);
      chk("br_over_lu_flushe", FlushE, 1);
      MemtoRegE = 0; RegWriteE = 0;
      cyc();

      // Branch held through a 3-cycle Stuck window
      MemAccessM = 1; #1;
      chk("br_stuck0_flushd", FlushD, 0);
      chk("br_stuck0_flushe", FlushE, 0);
      cyc();
      chk("br_stuck1_flushe", FlushE, 0);
      chk("br_stuck1_stalld", StallD, 1);
      cyc();
      mem_ack = 1; #1;
      chk("br_stuck2_flushd", FlushD, 0);
      cyc();
      mem_ack = 0; #1;
      chk("br_rel_flushd", FlushD, 1);
      chk("br_rel_flushe", FlushE, 1);
      chk("br_rel_stallf", StallF, 0);
      chk("br_stall_cycles", stall_cycles, st(28));
      chk("br_mem_accesses", mem_accesses, st(4));
      BranchTakenE = 0;
      cyc();

      // Reset pulsed in the middle of WAIT
      cyc();
      chk("mid_req_before", mem_req, 1);
      rst = 1; MemAccessM = 0; #1;
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_stuck", Stuck, 0);
      chk("mid_rst_stall_cycles", stall_cycles, 0);
      chk("mid_rst_timeout", timeout_err, 0);
      cyc();
      rst = 0;
      cyc();
      chk("post_rst_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1, "watchdog");
   end
endmodule
